// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types: per-axis porch/sync description, default 640x480@60 timings
// and the helper that turns an axis description into its total period.
package vga_timing_pkg;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } vga_axis_t;

    localparam vga_axis_t VGA_640X480_H = '{active: 640, fp: 16, sync: 96, bp: 48};
    localparam vga_axis_t VGA_640X480_V = '{active: 480, fp: 10, sync: 2,  bp: 33};

    function automatic int axis_total(vga_axis_t a);
        return a.active + a.fp + a.sync + a.bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered sync, active and
// last-position flags, all decoded from the next count so they line up with it.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter vga_axis_t AXIS  = VGA_640X480_H,
    parameter bit        POL   = 1'b0,
    parameter int        CNT_W = 16
) (
    input  logic             clk_25MHz,
    input  logic             rst,
    input  logic             ce,
    output logic [CNT_W-1:0] count,
    output logic             sync,
    output logic             active,
    output logic             wrap
);

    localparam int TOTAL = axis_total(AXIS);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(AXIS.active);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(AXIS.active + AXIS.fp);
    localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(AXIS.active + AXIS.fp + AXIS.sync);

    logic [CNT_W-1:0] count_next;
    logic             in_sync_next;

    always_comb begin
        count_next = count;
        if (ce) begin
            count_next = (count == LAST) ? '0 : count + CNT_W'(1);
        end
        in_sync_next = (count_next >= SYNC_START) && (count_next < SYNC_END);
    end

    // wrap only arms on a real advance, so the parked post-reset position never strobes
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            count  <= LAST;
            sync   <= ~POL;
            active <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            count  <= count_next;
            sync   <= in_sync_next ? POL : ~POL;
            active <= (count_next < ACT_END);
            if (ce) begin
                wrap <= (count_next == LAST);
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal and vertical axis counters, syncs, display enable
// and line/frame strobes. Define VGA_FRAME_CNT_EN to add the completed-frame counter port.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CNT_W     = 16,
    parameter int FRAME_W   = 8
) (
    input  logic               clk_25MHz,
    input  logic               rst,
    input  logic               ce,
    output logic [CNT_W-1:0]   h_count,
    output logic [CNT_W-1:0]   v_count,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               line_end,
    output logic               frame_end
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [FRAME_W-1:0] frame_cnt
`endif
);

    localparam vga_axis_t H_AXIS = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam vga_axis_t V_AXIS = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
    localparam int H_TOTAL = axis_total(H_AXIS);
    localparam int V_TOTAL = axis_total(V_AXIS);

    if ((64'd1 << CNT_W) < 64'(H_TOTAL) || (64'd1 << CNT_W) < 64'(V_TOTAL) || FRAME_W < 1)
    begin : g_width_check
        $error("vga_timing_gen: CNT_W too small for timing totals, or FRAME_W < 1");
    end

    logic h_active, v_active;
    logic h_wrap, v_wrap;
    logic h_last;
    logic v_ce;

    // v steps on the edge that takes h from its last position back to 0
    assign h_last = (h_count == CNT_W'(H_TOTAL - 1));
    assign v_ce   = ce & h_last;

    vga_axis_counter #(
        .AXIS  (H_AXIS),
        .POL   (HSYNC_POL),
        .CNT_W (CNT_W)
    ) u_h_axis (
        .clk_25MHz (clk_25MHz),
        .rst       (rst),
        .ce        (ce),
        .count     (h_count),
        .sync      (hsync),
        .active    (h_active),
        .wrap      (h_wrap)
    );

    vga_axis_counter #(
        .AXIS  (V_AXIS),
        .POL   (VSYNC_POL),
        .CNT_W (CNT_W)
    ) u_v_axis (
        .clk_25MHz (clk_25MHz),
        .rst       (rst),
        .ce        (v_ce),
        .count     (v_count),
        .sync      (vsync),
        .active    (v_active),
        .wrap      (v_wrap)
    );

    assign de        = h_active & v_active;
    assign line_end  = h_wrap & ce & ~rst;
    assign frame_end = line_end & v_wrap;

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_end) begin
            frame_cnt <= frame_cnt + FRAME_W'(1);
        end
    end
`endif

endmodule
